// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM states.
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Pure combinational lane logic: store byte-enable/data steering and load
// byte/half extraction with sign or zero extension.
module load_store_unit_align
   import load_store_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN / 8
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] load_word,
   output logic [BE_W-1:0] be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_ext
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Store side: replicate the data across lanes and enable only the target bytes.
   always_comb begin
      be    = '0;
      wdata = '0;
      case (funct3[1:0])
         2'b00: begin
            be    = BE_W'(1) << offset;
            wdata = {(XLEN/8){store_data[7:0]}};
         end
         2'b01: begin
            be    = offset[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
            wdata = {(XLEN/16){store_data[15:0]}};
         end
         default: begin
            be    = '1;
            wdata = store_data;
         end
      endcase
   end

   // Load side: pick the addressed lane, then extend according to the width code.
   always_comb begin
      lane_byte = load_word[7:0];
      case (offset)
         2'd0:    lane_byte = load_word[7:0];
         2'd1:    lane_byte = load_word[15:8];
         2'd2:    lane_byte = load_word[23:16];
         default: lane_byte = load_word[31:24];
      endcase
      lane_half = offset[1] ? load_word[31:16] : load_word[15:0];
      case (funct3)
         F3_B:    load_ext = {{(XLEN-8){lane_byte[7]}}, lane_byte};
         F3_BU:   load_ext = {{(XLEN-8){1'b0}}, lane_byte};
         F3_H:    load_ext = {{(XLEN-16){lane_half[15]}}, lane_half};
         F3_HU:   load_ext = {{(XLEN-16){1'b0}}, lane_half};
         default: load_ext = load_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: checks each access, drives a single-outstanding memory
// port and returns aligned, extended load data while stalling the core.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN / 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_load,
   input  logic            ex_store,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   output logic            lsu_stall,
   output logic            lsu_done,
   output logic [XLEN-1:0] load_data,
   output logic            misaligned,
   output logic            illegal,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [BE_W-1:0] mem_be,
   input  logic            mem_ready,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   lsu_state_t      state, nextState;
   logic [1:0]      offsetQ;
   logic [2:0]      funct3Q;
   logic [BE_W-1:0] beQ;
   logic [XLEN-1:0] wdataQ;
   logic [XLEN-1:0] addrQ;
   logic            weQ;

   logic            access;
   logic            badFunct3;
   logic            illegalC;
   logic            misalignedC;
   logic            doneC;
   logic            reqC;
   logic            capture;
   logic            loadUpdate;

   logic [2:0]      alignFunct3;
   logic [1:0]      alignOffset;
   logic [BE_W-1:0] alignBe;
   logic [XLEN-1:0] alignWdata;
   logic [XLEN-1:0] alignLoad;

   // Classify the incoming access; a load and store together is always illegal.
   always_comb begin
      access      = ex_valid & (ex_load | ex_store);
      badFunct3   = ex_load ? (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                            : (funct3 > F3_W);
      illegalC    = (ex_load & ex_store) | badFunct3;
      misalignedC = ((funct3[1:0] == 2'b01) & addr[0]) |
                    ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
   end

   // In IDLE the aligner sees the new instruction; afterwards the latched access.
   always_comb begin
      alignFunct3 = (state == IDLE) ? funct3    : funct3Q;
      alignOffset = (state == IDLE) ? addr[1:0] : offsetQ;
   end

   load_store_unit_align #(.XLEN(XLEN), .BE_W(BE_W)) u_align (
      .funct3     (alignFunct3),
      .offset     (alignOffset),
      .store_data (store_data),
      .load_word  (mem_rdata),
      .be         (alignBe),
      .wdata      (alignWdata),
      .load_ext   (alignLoad)
   );

   // FSM state register; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state and per-cycle control: exceptions finish in IDLE, others go to memory.
   always_comb begin
      nextState  = state;
      doneC      = 1'b0;
      reqC       = 1'b0;
      capture    = 1'b0;
      loadUpdate = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (illegalC || misalignedC) begin
                  doneC = 1'b1;
               end else begin
                  capture   = 1'b1;
                  nextState = REQ;
               end
            end
         end
         REQ: begin
            reqC = 1'b1;
            if (mem_ready) begin
               if (weQ) begin
                  doneC     = 1'b1;
                  nextState = IDLE;
               end else if (mem_rvalid) begin
                  doneC      = 1'b1;
                  loadUpdate = 1'b1;
                  nextState  = IDLE;
               end else begin
                  nextState = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               doneC      = 1'b1;
               loadUpdate = 1'b1;
               nextState  = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Latch the request fields so they stay stable until memory accepts them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         offsetQ <= '0;
         funct3Q <= '0;
         beQ     <= '0;
         wdataQ  <= '0;
         addrQ   <= '0;
         weQ     <= 1'b0;
      end else if (capture) begin
         offsetQ <= addr[1:0];
         funct3Q <= funct3;
         beQ     <= alignBe;
         wdataQ  <= alignWdata;
         addrQ   <= {addr[XLEN-1:2], 2'b00};
         weQ     <= ex_store;
      end
   end

   // Load result register changes only when a load completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          load_data <= '0;
      else if (loadUpdate) load_data <= alignLoad;
   end

   // Outputs are forced low while reset is held, even with ex_valid still asserted.
   always_comb begin
      lsu_done   = rst_n & doneC;
      illegal    = rst_n & (state == IDLE) & access & illegalC;
      misaligned = rst_n & (state == IDLE) & access & ~illegalC & misalignedC;
      lsu_stall  = rst_n & ~doneC & (access | (state != IDLE));
      mem_req    = rst_n & reqC;
      mem_we     = rst_n & reqC & weQ;
      mem_be     = (rst_n & reqC) ? beQ : '0;
      mem_addr   = addrQ;
      mem_wdata  = wdataQ;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for the load/store unit.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid, ex_load, ex_store;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        lsu_stall, lsu_done, misaligned, illegal;
   logic [31:0] load_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;

   int checkCount = 0;
   int passCount  = 0;

   load_store_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ex_valid   (ex_valid),
      .ex_load    (ex_load),
      .ex_store   (ex_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .lsu_stall  (lsu_stall),
      .lsu_done   (lsu_done),
      .load_data  (load_data),
      .misaligned (misaligned),
      .illegal    (illegal),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   // Free-running core clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic v, input logic l, input logic s, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd);
      ex_valid   = v;
      ex_load    = l;
      ex_store   = s;
      funct3     = f3;
      addr       = a;
      store_data = sd;
   endtask

   task automatic memResponse(input logic rdy, input logic rv, input logic [31:0] rd);
      mem_ready  = rdy;
      mem_rvalid = rv;
      mem_rdata  = rd;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Load accepted on the first REQ cycle, data returned after gap empty WAIT cycles.
   task automatic runWaitedLoad(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] rd, input int gap, input logic [31:0] expected);
      applyStimulus(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
      memResponse(1'b0, 1'b0, 32'h0);
      nextCycle();
      memResponse(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput({tag, "_req"}, {31'b0, mem_req}, 32'h1);
      checkOutput({tag, "_we"}, {31'b0, mem_we}, 32'h0);
      checkOutput({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      nextCycle();
      memResponse(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         checkOutput({tag, "_waitstall"}, {31'b0, lsu_stall}, 32'h1);
         checkOutput({tag, "_waitreq"}, {31'b0, mem_req}, 32'h0);
         checkOutput({tag, "_waitdone"}, {31'b0, lsu_done}, 32'h0);
         nextCycle();
      end
      memResponse(1'b0, 1'b1, rd);
      @(negedge clk);
      checkOutput({tag, "_done"}, {31'b0, lsu_done}, 32'h1);
      nextCycle();
      memResponse(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput({tag, "_data"}, load_data, expected);
      checkOutput({tag, "_idle"}, {31'b0, lsu_done}, 32'h0);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      memResponse(1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("rst_stall", {31'b0, lsu_stall}, 32'h0);
      checkOutput("rst_req", {31'b0, mem_req}, 32'h0);
      checkOutput("rst_done", {31'b0, lsu_done}, 32'h0);
      checkOutput("rst_ldata", load_data, 32'h0);
      nextCycle();
      rst_n = 1'b1;

      // SW with memory ready on the first request cycle
      applyStimulus(1'b1, 1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("sw_acc_stall", {31'b0, lsu_stall}, 32'h1);
      checkOutput("sw_acc_req", {31'b0, mem_req}, 32'h0);
      nextCycle();
      memResponse(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("sw_req", {31'b0, mem_req}, 32'h1);
      checkOutput("sw_we", {31'b0, mem_we}, 32'h1);
      checkOutput("sw_addr", mem_addr, 32'h100);
      checkOutput("sw_be", {28'b0, mem_be}, 32'hF);
      checkOutput("sw_wdata", mem_wdata, 32'hDEADBEEF);
      checkOutput("sw_done", {31'b0, lsu_done}, 32'h1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      memResponse(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("sw_after_req", {31'b0, mem_req}, 32'h0);
      checkOutput("sw_after_be", {28'b0, mem_be}, 32'h0);
      checkOutput("sw_after_we", {31'b0, mem_we}, 32'h0);

      // SB to the top lane with one cycle of memory backpressure
      applyStimulus(1'b1, 1'b0, 1'b1, F3_B, 32'h203, 32'h000000A5);
      nextCycle();
      @(negedge clk);
      checkOutput("sb_req", {31'b0, mem_req}, 32'h1);
      checkOutput("sb_addr", mem_addr, 32'h200);
      checkOutput("sb_be", {28'b0, mem_be}, 32'h8);
      checkOutput("sb_wdata", mem_wdata, 32'hA5A5A5A5);
      checkOutput("sb_hold_done", {31'b0, lsu_done}, 32'h0);
      checkOutput("sb_hold_stall", {31'b0, lsu_stall}, 32'h1);
      nextCycle();
      memResponse(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("sb_done", {31'b0, lsu_done}, 32'h1);
      checkOutput("sb_be_held", {28'b0, mem_be}, 32'h8);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      memResponse(1'b0, 1'b0, 32'h0);

      // Byte loads from lane 2 with rvalid three cycles after ready
      runWaitedLoad("lb", F3_B, 32'h302, 32'h12803456, 2, 32'hFFFFFF80);
      runWaitedLoad("lbu", F3_BU, 32'h302, 32'h12803456, 2, 32'h00000080);

      // Misaligned halfword load
      applyStimulus(1'b1, 1'b1, 1'b0, F3_H, 32'h401, 32'h0);
      @(negedge clk);
      checkOutput("mis_flag", {31'b0, misaligned}, 32'h1);
      checkOutput("mis_ill", {31'b0, illegal}, 32'h0);
      checkOutput("mis_done", {31'b0, lsu_done}, 32'h1);
      checkOutput("mis_req", {31'b0, mem_req}, 32'h0);
      checkOutput("mis_stall", {31'b0, lsu_stall}, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("mis_after_req", {31'b0, mem_req}, 32'h0);

      // Load with reserved width code 011
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("ill_flag", {31'b0, illegal}, 32'h1);
      checkOutput("ill_done", {31'b0, lsu_done}, 32'h1);
      checkOutput("ill_req", {31'b0, mem_req}, 32'h0);
      nextCycle();

      // Load and store both set on a misaligned word: illegal wins
      applyStimulus(1'b1, 1'b1, 1'b1, F3_W, 32'h102, 32'h0);
      @(negedge clk);
      checkOutput("both_ill", {31'b0, illegal}, 32'h1);
      checkOutput("both_mis", {31'b0, misaligned}, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("ldata_kept", load_data, 32'h00000080);
      checkOutput("nothing_req", {31'b0, mem_req}, 32'h0);

      // LHU with ready and rvalid together
      applyStimulus(1'b1, 1'b1, 1'b0, F3_HU, 32'h502, 32'h0);
      nextCycle();
      memResponse(1'b1, 1'b1, 32'hBEEF1234);
      @(negedge clk);
      checkOutput("lhu_req", {31'b0, mem_req}, 32'h1);
      checkOutput("lhu_done", {31'b0, lsu_done}, 32'h1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      memResponse(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("lhu_data", load_data, 32'h0000BEEF);
      checkOutput("lhu_idle", {31'b0, lsu_done}, 32'h0);

      // Signed halfword from lane 0, then a full word
      runWaitedLoad("lh", F3_H, 32'h500, 32'h00008001, 0, 32'hFFFF8001);
      runWaitedLoad("lw", F3_W, 32'h504, 32'h13579BDF, 1, 32'h13579BDF);

      // Reset while a load sits in WAIT, then a stray rvalid
      applyStimulus(1'b1, 1'b1, 1'b0, F3_W, 32'h600, 32'h0);
      nextCycle();
      memResponse(1'b1, 1'b0, 32'h0);
      nextCycle();
      memResponse(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("rw_wait_stall", {31'b0, lsu_stall}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rw_req", {31'b0, mem_req}, 32'h0);
      checkOutput("rw_stall", {31'b0, lsu_stall}, 32'h0);
      checkOutput("rw_ldata", load_data, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      rst_n = 1'b1;
      memResponse(1'b0, 1'b1, 32'hFFFFFFFF);
      @(negedge clk);
      checkOutput("stray_done", {31'b0, lsu_done}, 32'h0);
      checkOutput("stray_stall", {31'b0, lsu_stall}, 32'h0);
      nextCycle();
      memResponse(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("stray_ldata", load_data, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
